uart_seg_display_ctrl: RTL and testbench

//  Command controller between the UART byte receiver and a multiplexed 7-segment display.

---
 rtl/uart_seg_display_ctrl_if.sv | 30 +++
 rtl/uart_seg_display_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_uart_seg_display_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_seg_display_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_seg_display_ctrl_if
// Description : Bundles the received-byte strobe and the multiplexed display
//               outputs of uart_seg_display_ctrl into one interface.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_seg_display_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic [7:0]            rx_byte;
    logic                  rx_valid;
    logic [6:0]            seg;
    logic [NUM_DIGITS-1:0] dig_en;
    logic                  disp_upd;
    logic                  cmd_err;

    // Byte source / display sink side
    modport master (
        output rx_byte, rx_valid,
        input  seg, dig_en, disp_upd, cmd_err
    );

    // Controller side
    modport slave (
        input  rx_byte, rx_valid,
        output seg, dig_en, disp_upd, cmd_err
    );
endinterface
`default_nettype wire

// File: rtl/uart_seg_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_seg_display_ctrl
// Description : Parses ASCII bytes from the UART receiver into a shadow digit
//               buffer, commits it on CR/LF and time-multiplexes the committed
//               digits onto a shared 7-segment bus.
//               Optional macro BLANK_LEADING_ZERO_EN blanks leading zeros
//               (digit 0 always shown).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_seg_display_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 6750
) (
    input  wire logic               clk,
    input  wire logic               reset_n,
    uart_seg_display_ctrl_if.slave  bus
);
    localparam int              c_BUF_W  = NUM_DIGITS * 5;
    localparam int              c_CNT_W  = $clog2(NUM_DIGITS + 1);
    localparam int              c_SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [1:0]      c_ST_IDLE  = 2'd0;
    localparam logic [1:0]      c_ST_ACCUM = 2'd1;
    localparam logic [1:0]      c_ST_ERROR = 2'd2;
    localparam logic [NUM_DIGITS-1:0] c_DIG0 = NUM_DIGITS'(1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_BUF_W-1:0]    r_shadow;     // per digit {valid, bcd[3:0]}
    logic [c_BUF_W-1:0]    r_display;
    logic [c_SCAN_W-1:0]   r_scan_cnt;
    logic [NUM_DIGITS-1:0] r_dig_en;
    logic [6:0]            r_seg;
    logic                  r_disp_upd;
    logic                  r_cmd_err;

    logic                  w_is_digit;
    logic                  w_is_eol;
    logic                  w_is_clear;
    logic                  w_shift;
    logic                  w_commit;
    logic                  w_clear;
    logic                  w_err_enter;
    logic [NUM_DIGITS-1:0] w_show;
    logic [3:0]            w_sel_bcd;
    logic                  w_sel_show;
`ifdef BLANK_LEADING_ZERO_EN
    logic                  w_lz_run;
`endif

    // Seven-segment pattern {g,f,e,d,c,b,a} for one BCD digit
    function automatic logic [6:0] f_seg(input logic [3:0] bcd);
        case (bcd)
            4'd0:    f_seg = 7'h3F;
            4'd1:    f_seg = 7'h06;
            4'd2:    f_seg = 7'h5B;
            4'd3:    f_seg = 7'h4F;
            4'd4:    f_seg = 7'h66;
            4'd5:    f_seg = 7'h6D;
            4'd6:    f_seg = 7'h7D;
            4'd7:    f_seg = 7'h07;
            4'd8:    f_seg = 7'h7F;
            4'd9:    f_seg = 7'h6F;
            default: f_seg = 7'h00;
        endcase
    endfunction

    // Classify the incoming byte
    always_comb begin
        w_is_digit = (bus.rx_byte >= 8'h30) && (bus.rx_byte <= 8'h39);
        w_is_eol   = (bus.rx_byte == 8'h0D) || (bus.rx_byte == 8'h0A);
        w_is_clear = (bus.rx_byte == 8'h43) || (bus.rx_byte == 8'h63);
    end

    // Command parser: next state and one-cycle buffer actions
    always_comb begin
        w_state_nxt = r_state;
        w_shift     = 1'b0;
        w_commit    = 1'b0;
        w_clear     = 1'b0;
        w_err_enter = 1'b0;
        if (bus.rx_valid) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_is_digit) begin
                        w_shift     = 1'b1;
                        w_state_nxt = c_ST_ACCUM;
                    end else if (w_is_clear) begin
                        w_clear     = 1'b1;
                    end else if (!w_is_eol) begin
                        w_err_enter = 1'b1;
                        w_state_nxt = c_ST_ERROR;
                    end
                end
                c_ST_ACCUM: begin
                    if (w_is_digit) begin
                        w_shift     = 1'b1;
                    end else if (w_is_eol) begin
                        w_commit    = 1'b1;
                        w_state_nxt = c_ST_IDLE;
                    end else if (w_is_clear) begin
                        w_clear     = 1'b1;
                        w_state_nxt = c_ST_IDLE;
                    end else begin
                        w_err_enter = 1'b1;
                        w_state_nxt = c_ST_ERROR;
                    end
                end
                c_ST_ERROR: begin
                    if (w_is_eol) w_state_nxt = c_ST_IDLE;
                end
                default: w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    // Parser state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= c_ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Shadow/display buffers, digit count and event pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow   <= '0;
            r_display  <= '0;
            r_cnt      <= '0;
            r_disp_upd <= 1'b0;
            r_cmd_err  <= 1'b0;
        end else begin
            r_disp_upd <= w_commit | w_clear;
            r_cmd_err  <= w_err_enter;
            if (w_shift) begin
                // Newest digit enters on the right; the oldest falls off the left
                r_shadow <= {r_shadow[c_BUF_W-6:0], 1'b1, bus.rx_byte[3:0]};
                if (r_state == c_ST_IDLE)                   r_cnt <= c_CNT_W'(1);
                else if (r_cnt != c_CNT_W'(NUM_DIGITS))     r_cnt <= r_cnt + 1'b1;
            end
            if (w_commit) begin
                r_display <= r_shadow;
                r_shadow  <= '0;
                r_cnt     <= '0;
            end
            if (w_clear) begin
                r_display <= '0;
                r_shadow  <= '0;
                r_cnt     <= '0;
            end
            if (w_err_enter) begin
                r_shadow  <= '0;
                r_cnt     <= '0;
            end
        end
    end

    // Digit slot timer and one-hot digit rotation
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scan_cnt <= '0;
            r_dig_en   <= c_DIG0;
        end else if (r_scan_cnt == c_SCAN_W'(SCAN_DIV - 1)) begin
            r_scan_cnt <= '0;
            r_dig_en   <= {r_dig_en[NUM_DIGITS-2:0], r_dig_en[NUM_DIGITS-1]};
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    // Per-digit visibility: valid digits, optionally minus leading zeros
    always_comb begin
        w_show = '0;
`ifdef BLANK_LEADING_ZERO_EN
        w_lz_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (r_display[i*5+4] && (r_display[i*5 +: 4] != 4'd0)) w_lz_run = 1'b0;
            w_show[i] = r_display[i*5+4] && !(w_lz_run && (i != 0));
        end
`else
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_show[i] = r_display[i*5+4];
        end
`endif
    end

    // Select the display entry addressed by the active digit enable
    always_comb begin
        w_sel_bcd  = '0;
        w_sel_show = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_dig_en[i]) begin
                w_sel_bcd  = r_display[i*5 +: 4];
                w_sel_show = w_show[i];
            end
        end
    end

    // Segment bus is refreshed every cycle so commits appear without waiting for a slot
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        r_seg <= 7'h00;
        else if (w_sel_show) r_seg <= f_seg(w_sel_bcd);
        else                 r_seg <= 7'h00;
    end

    assign bus.seg      = r_seg;
    assign bus.dig_en   = r_dig_en;
    assign bus.disp_upd = r_disp_upd;
    assign bus.cmd_err  = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_seg_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_seg_display_ctrl
// Description : Self-checking bench for uart_seg_display_ctrl: command vectors
//               with expected digit patterns, plus a pulse scoreboard fed by a
//               small command-parser model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_seg_display_ctrl;
    localparam int NUM_DIGITS = 4;
    localparam int SCAN_DIV   = 8;
    localparam int NVEC       = 13;

    typedef struct packed {
        logic [63:0] cmd;
        logic [31:0] len;
        logic [6:0]  s3;
        logic [6:0]  s2;
        logic [6:0]  s1;
        logic [6:0]  s0;
    } vec_t;

    typedef struct packed {
        int   cyc;
        logic upd;
        logic err;
    } ev_t;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   m_state = 0;   // 0 idle, 1 accumulating, 2 error
    ev_t  q[$];
    ev_t  m_ev;
    vec_t vecs[NVEC];

    uart_seg_display_ctrl_if #(.NUM_DIGITS(NUM_DIGITS)) bus ();

    uart_seg_display_ctrl #(
        .NUM_DIGITS(NUM_DIGITS),
        .SCAN_DIV  (SCAN_DIV)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse scoreboard: expected pulses are compared on their cycle, any other pulse is flagged
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].cyc == cyc) begin
            m_ev = q.pop_front();
            checks++;
            if (bus.disp_upd !== m_ev.upd || bus.cmd_err !== m_ev.err) begin
                errors++;
                $display("FAIL pulse cyc=%0d: got upd=%b err=%b, expected upd=%b err=%b",
                         cyc, bus.disp_upd, bus.cmd_err, m_ev.upd, m_ev.err);
            end
        end else if (bus.disp_upd !== 1'b0 || bus.cmd_err !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse cyc=%0d: got upd=%b err=%b, expected 0 0",
                     cyc, bus.disp_upd, bus.cmd_err);
        end
    end

    function automatic vec_t mk(input logic [63:0] c, input int n,
                                input logic [6:0] a3, input logic [6:0] a2,
                                input logic [6:0] a1, input logic [6:0] a0);
        vec_t v;
        v.cmd = c; v.len = n; v.s3 = a3; v.s2 = a2; v.s1 = a1; v.s0 = a0;
        return v;
    endfunction

    function automatic logic [6:0] exp_seg(input vec_t v, input int d);
        case (d)
            0:       return v.s0;
            1:       return v.s1;
            2:       return v.s2;
            default: return v.s3;
        endcase
    endfunction

    function automatic int onehot_idx(input logic [NUM_DIGITS-1:0] oh);
        for (int i = 0; i < NUM_DIGITS; i++) if (oh[i]) return i;
        return 0;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Drive one byte for one cycle; the model predicts its pulse and queues it
    task automatic send_byte(input logic [7:0] b);
        logic upd, err, is_d, eol, clr;
        upd  = 1'b0;
        err  = 1'b0;
        is_d = (b >= 8'h30) && (b <= 8'h39);
        eol  = (b == 8'h0D) || (b == 8'h0A);
        clr  = (b == 8'h43) || (b == 8'h63);
        case (m_state)
            0: if (is_d) m_state = 1;
               else if (clr) upd = 1'b1;
               else if (!eol) begin err = 1'b1; m_state = 2; end
            1: if (is_d) m_state = 1;
               else if (eol || clr) begin upd = 1'b1; m_state = 0; end
               else begin err = 1'b1; m_state = 2; end
            default: if (eol) m_state = 0;
        endcase
        bus.rx_byte  = b;
        bus.rx_valid = 1'b1;
        if (upd || err) q.push_back('{cyc: cyc + 1, upd: upd, err: err});
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    // Wait for a full slot of digit d and compare the segment bus
    task automatic check_digit(input int d, input logic [6:0] exp, input string name);
        logic [NUM_DIGITS-1:0] tgt, prev;
        int n;
        tgt  = NUM_DIGITS'(1) << d;
        prev = bus.dig_en;
        @(negedge clk);
        n = 1;
        while (!(prev === tgt && bus.dig_en === tgt) && n < 4 * SCAN_DIV + 8) begin
            prev = bus.dig_en;
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(prev === tgt && bus.dig_en === tgt)) begin
            errors++;
            $display("FAIL %s digit%0d: dig_en timeout, got %b, expected %b", name, d, bus.dig_en, tgt);
        end else if (bus.seg !== exp) begin
            errors++;
            $display("FAIL %s digit%0d: seg got %h, expected %h", name, d, bus.seg, exp);
        end
    endtask

    task automatic drain_check(input string name);
        repeat (2) @(negedge clk);
        check({name, " queue_empty"}, q.size(), 0);
    endtask

    initial begin
        logic [NUM_DIGITS-1:0] d_before;
        logic [NUM_DIGITS-1:0] exp_en;

        vecs[0]  = mk("12\r",      3, 7'h00, 7'h00, 7'h06, 7'h5B);
        vecs[1]  = mk("123456\n",  7, 7'h4F, 7'h66, 7'h6D, 7'h7D);
        vecs[2]  = mk("7x9\r",     4, 7'h4F, 7'h66, 7'h6D, 7'h7D);
        vecs[3]  = mk("5\r",       2, 7'h00, 7'h00, 7'h00, 7'h6D);
        vecs[4]  = mk("42\r",      3, 7'h00, 7'h00, 7'h66, 7'h5B);
        vecs[5]  = mk("C",         1, 7'h00, 7'h00, 7'h00, 7'h00);
        vecs[6]  = mk("\r\n",      2, 7'h00, 7'h00, 7'h00, 7'h00);
`ifdef BLANK_LEADING_ZERO_EN
        vecs[7]  = mk("0070\r",    5, 7'h00, 7'h00, 7'h07, 7'h3F);
        vecs[11] = mk("00000\n",   6, 7'h00, 7'h00, 7'h00, 7'h3F);
`else
        vecs[7]  = mk("0070\r",    5, 7'h3F, 7'h3F, 7'h07, 7'h3F);
        vecs[11] = mk("00000\n",   6, 7'h3F, 7'h3F, 7'h3F, 7'h3F);
`endif
        vecs[8]  = mk("8\r",       2, 7'h00, 7'h00, 7'h00, 7'h7F);
        vecs[9]  = mk("Z5\r",      3, 7'h00, 7'h00, 7'h00, 7'h7F);
        vecs[10] = mk("9c",        2, 7'h00, 7'h00, 7'h00, 7'h00);
        vecs[12] = mk("88\r\n",    4, 7'h00, 7'h00, 7'h7F, 7'h7F);

        // Reset values
        reset_n      = 1'b0;
        bus.rx_byte  = 8'h00;
        bus.rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst seg", bus.seg, 7'h00);
        check("rst dig_en", bus.dig_en, 4'b0001);
        check("rst disp_upd", bus.disp_upd, 1'b0);
        check("rst cmd_err", bus.cmd_err, 1'b0);
        reset_n = 1'b1;

        // Scan rotation: each enable holds for exactly SCAN_DIV cycles
        exp_en = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            repeat (SCAN_DIV - 1) @(negedge clk);
            check("scan hold", bus.dig_en, exp_en);
            @(negedge clk);
            exp_en = {exp_en[NUM_DIGITS-2:0], exp_en[NUM_DIGITS-1]};
            check("scan rotate", bus.dig_en, exp_en);
            check("scan seg blank", bus.seg, 7'h00);
        end

        // Command vectors
        for (int v = 0; v < NVEC; v++) begin
            for (int i = 0; i < int'(vecs[v].len); i++) begin
                send_byte(vecs[v].cmd[8*(int'(vecs[v].len)-1-i) +: 8]);
            end
            // New display content reaches the active digit one cycle later
            d_before = bus.dig_en;
            @(negedge clk);
            check($sformatf("vec%0d seg_next_cycle", v), bus.seg,
                  exp_seg(vecs[v], onehot_idx(d_before)));
            for (int d = 0; d < NUM_DIGITS; d++) begin
                check_digit(d, exp_seg(vecs[v], d), $sformatf("vec%0d", v));
            end
            drain_check($sformatf("vec%0d", v));
        end

        // Reset in the middle of "98": partial entry is lost
        send_byte(8'h39);
        reset_n = 1'b0;
        m_state = 0;
        q.delete();
        #1;
        check("midrst seg", bus.seg, 7'h00);
        check("midrst dig_en", bus.dig_en, 4'b0001);
        check("midrst disp_upd", bus.disp_upd, 1'b0);
        check("midrst cmd_err", bus.cmd_err, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        send_byte(8'h0D);
        for (int d = 0; d < NUM_DIGITS; d++) begin
            check_digit(d, 7'h00, "midrst");
        end
        drain_check("midrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
